// File: rtl/branch_seq.sv
// ---------------------------------------------------------------------------
// branch_seq -- resolves MIPS conditional branches sitting in the ID stage.
//
// A branch seen in ID is captured (opcode, rt field, precomputed target and
// link address). The sequencer waits until its forwarded operands are valid,
// evaluates the condition for one or more cycles, then lets the delay slot
// through. While a branch is waiting or being evaluated it holds IF/ID.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   id_valid             instruction present in ID
//   id_op, id_rt         opcode and rt fields of the ID instruction
//   id_imm, id_pc        branch offset and PC of the branch
//   rs_data, rt_data     forwarded operands
//   rs_ready, rt_ready   operand valid this cycle
//   pipe_stall           downstream hold
//   flush                exception flush; abandons any branch in flight
//   br_stall             hold IF/ID (WAIT and EVAL)
//   br_redirect          load br_target into the PC (one cycle per taken branch)
//   br_target            pc + 4 + (sign_extend(imm) << 2)
//   br_link, br_link_addr  write pc + 8 into r31 (BGEZAL / BLTZAL)
//   br_cnt, taken_cnt    resolved / taken branch counters, 16-bit wrapping
// ---------------------------------------------------------------------------
module branch_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rt,
  input  logic [15:0] id_imm,
  input  logic [31:0] id_pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        br_stall,
  output logic        br_redirect,
  output logic [31:0] br_target,
  output logic        br_link,
  output logic [31:0] br_link_addr,
  output logic [15:0] br_cnt,
  output logic [15:0] taken_cnt
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_DSLOT
  } state_t;

  state_t state, state_nxt;

  // Latched branch context
  logic [5:0]  op_q;
  logic [4:0]  rt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  // ---------------------------------------------------------------------------
  // Decode of the instruction currently in ID
  // ---------------------------------------------------------------------------
  logic id_regimm_br;
  logic id_is_br;
  logic id_need_rt;
  logic id_ops_ready;

  assign id_regimm_br = (id_op == OP_REGIMM) &&
                        ((id_rt == RT_BLTZ)   || (id_rt == RT_BGEZ) ||
                         (id_rt == RT_BLTZAL) || (id_rt == RT_BGEZAL));
  assign id_is_br     = id_valid &&
                        ((id_op == OP_BEQ)  || (id_op == OP_BNE) ||
                         (id_op == OP_BLEZ) || (id_op == OP_BGTZ) || id_regimm_br);
  // Only the two-operand compares depend on rt; everything else is rs-only.
  assign id_need_rt   = (id_op == OP_BEQ) || (id_op == OP_BNE);
  assign id_ops_ready = rs_ready && (!id_need_rt || rt_ready);

  // ---------------------------------------------------------------------------
  // Decode of the latched branch
  // ---------------------------------------------------------------------------
  logic q_need_rt;
  logic q_ops_ready;
  logic q_taken;
  logic q_link;

  assign q_need_rt   = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign q_ops_ready = rs_ready && (!q_need_rt || rt_ready);
  assign q_link      = (op_q == OP_REGIMM) && ((rt_q == RT_BLTZAL) || (rt_q == RT_BGEZAL));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    q_taken = 1'b0;
    unique case (op_q)
      OP_BEQ:  q_taken = (a_q == b_q);
      OP_BNE:  q_taken = (a_q != b_q);
      OP_BLEZ: q_taken = ($signed(a_q) <= 32'sd0);
      OP_BGTZ: q_taken = ($signed(a_q) >  32'sd0);
      OP_REGIMM: begin
        if ((rt_q == RT_BGEZ) || (rt_q == RT_BGEZAL))
          q_taken = !a_q[31];
        else if ((rt_q == RT_BLTZ) || (rt_q == RT_BLTZAL))
          q_taken = a_q[31];
      end
      default: q_taken = 1'b0;
    endcase
  end

  // Qualified events
  logic capture;      // branch accepted from ID
  logic load_ops;     // operands latched this cycle
  logic leave_eval;   // branch resolved; counters advance

  assign capture    = (state == S_IDLE) && !flush && id_is_br && !pipe_stall;
  assign load_ops   = (capture && id_ops_ready) ||
                      ((state == S_WAIT) && !flush && q_ops_ready);
  assign leave_eval = (state == S_EVAL) && !flush && !pipe_stall;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (id_is_br && !pipe_stall) state_nxt = id_ops_ready ? S_EVAL : S_WAIT;
        S_WAIT:  if (q_ops_ready)             state_nxt = S_EVAL;
        S_EVAL:  if (!pipe_stall)             state_nxt = S_DSLOT;
        // A branch sitting in the delay slot is simply passed through.
        S_DSLOT: if (id_valid && !pipe_stall) state_nxt = S_IDLE;
        default:                              state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    br_stall    = (state == S_WAIT) || (state == S_EVAL);
    br_redirect = (state == S_EVAL) && q_taken && !pipe_stall && !flush;
    br_link     = (state == S_EVAL) && q_link && !flush;
  end

  // ---------------------------------------------------------------------------
  // Latched branch context. Target and link address are computed at capture
  // so the outputs come straight from registers and read zero out of reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the datapath registers are reset too, because their values are
    // visible on the outputs and must read zero during reset.
    if (!resetn) begin
      op_q         <= '0;
      rt_q         <= '0;
      br_target    <= '0;
      br_link_addr <= '0;
    end else if (capture) begin
      op_q         <= id_op;
      rt_q         <= id_rt;
      br_target    <= id_pc + 32'd4 + {{14{id_imm[15]}}, id_imm, 2'b00};
      br_link_addr <= id_pc + 32'd8;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load_ops) begin
      a_q <= rs_data;
      b_q <= rt_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (leave_eval) begin
      br_cnt <= br_cnt + 16'd1;
      if (q_taken) taken_cnt <= taken_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_seq.sv
// ---------------------------------------------------------------------------
// tb_branch_seq -- directed bench for branch_seq: a vector table of single
// branches (operands ready at capture) plus hand-written multi-cycle
// sequences for operand waits, pipe stalls, flush, reset and counter wrap.
// ---------------------------------------------------------------------------
module tb_branch_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [4:0]  id_rt;
  logic [15:0] id_imm;
  logic [31:0] id_pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_ready;
  logic        rt_ready;
  logic        pipe_stall;
  logic        flush;
  logic        br_stall;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        br_link;
  logic [31:0] br_link_addr;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  branch_seq dut (
    .clk          (clk),
    .resetn       (resetn),
    .id_valid     (id_valid),
    .id_op        (id_op),
    .id_rt        (id_rt),
    .id_imm       (id_imm),
    .id_pc        (id_pc),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .rs_ready     (rs_ready),
    .rt_ready     (rt_ready),
    .pipe_stall   (pipe_stall),
    .flush        (flush),
    .br_stall     (br_stall),
    .br_redirect  (br_redirect),
    .br_target    (br_target),
    .br_link      (br_link),
    .br_link_addr (br_link_addr),
    .br_cnt       (br_cnt),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] NOP = 6'h00, REGIMM = 6'h01, J = 6'h02;
  localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, BLEZ = 6'h06, BGTZ = 6'h07;

  typedef struct {
    string       name;
    logic        is_br;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rtd;
    logic        taken;
    logic        link;
    logic [31:0] target;
    logic [31:0] link_addr;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] bc_exp = '0;
  logic [15:0] tc_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic is_br, input logic [5:0] op,
                              input logic [4:0] rt, input logic [15:0] imm,
                              input logic [31:0] pc, input logic [31:0] rs,
                              input logic [31:0] rtd, input logic taken, input logic link,
                              input logic [31:0] target, input logic [31:0] link_addr);
    vec_t v;
    v.name = name; v.is_br = is_br; v.op = op; v.rt = rt; v.imm = imm; v.pc = pc;
    v.rs = rs; v.rtd = rtd; v.taken = taken; v.link = link; v.target = target;
    v.link_addr = link_addr;
    return v;
  endfunction

  task automatic idle_inputs();
    id_valid = 1'b0; id_op = NOP; id_rt = '0; id_imm = '0; id_pc = '0;
    rs_data = '0; rt_data = '0; rs_ready = 1'b0; rt_ready = 1'b0;
    pipe_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_branch(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm,
                              input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rtd,
                              input logic rsr, input logic rtr);
    id_valid = 1'b1; id_op = op; id_rt = rt; id_imm = imm; id_pc = pc;
    rs_data = rs; rt_data = rtd; rs_ready = rsr; rt_ready = rtr;
  endtask

  // Apply one table vector, starting and ending in IDLE.
  task automatic apply_vec(input vec_t v);
    // Only BEQ/BNE get rt_ready, so rs-only branches prove they ignore rt.
    drive_branch(v.op, v.rt, v.imm, v.pc, v.rs, v.rtd, 1'b1, (v.op == BEQ) || (v.op == BNE));
    @(negedge clk);
    check({v.name, "_idle_stall"}, {31'd0, br_stall}, 32'd0);
    step();
    if (v.is_br) begin
      id_op = NOP; rs_ready = 1'b0; rt_ready = 1'b0;
      @(negedge clk);
      check({v.name, "_eval_stall"}, {31'd0, br_stall}, 32'd1);
      check({v.name, "_redirect"}, {31'd0, br_redirect}, {31'd0, v.taken});
      check({v.name, "_link"}, {31'd0, br_link}, {31'd0, v.link});
      if (v.taken) check({v.name, "_target"}, br_target, v.target);
      if (v.link)  check({v.name, "_link_addr"}, br_link_addr, v.link_addr);
      bc_exp = bc_exp + 16'd1;
      if (v.taken) tc_exp = tc_exp + 16'd1;
      step();
      @(negedge clk);
      check({v.name, "_dslot_stall"}, {31'd0, br_stall}, 32'd0);
      check({v.name, "_dslot_redirect"}, {31'd0, br_redirect}, 32'd0);
      step();
    end else begin
      @(negedge clk);
      check({v.name, "_ignored_stall"}, {31'd0, br_stall}, 32'd0);
    end
    @(negedge clk);
    check({v.name, "_br_cnt"}, {16'd0, br_cnt}, {16'd0, bc_exp});
    check({v.name, "_taken_cnt"}, {16'd0, taken_cnt}, {16'd0, tc_exp});
    id_valid = 1'b0;
    step();
  endtask

  int stall_cycles;
  int redir_cycles;

  initial begin
    // Directed vectors with hand-computed targets / link addresses.
    vecs.push_back(mk("beq_eq",      1, BEQ,    5'h00, 16'h0004, 32'h0040_0000, 32'd5,         32'd5, 1, 0, 32'h0040_0014, 32'h0));
    vecs.push_back(mk("beq_ne",      1, BEQ,    5'h00, 16'h0004, 32'h0040_0000, 32'd5,         32'd6, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk("bne_taken",   1, BNE,    5'h00, 16'hFFFF, 32'h0000_1000, 32'd1,         32'd2, 1, 0, 32'h0000_1000, 32'h0));
    vecs.push_back(mk("blez_zero",   1, BLEZ,   5'h00, 16'h0010, 32'h0000_2000, 32'd0,         32'd9, 1, 0, 32'h0000_2044, 32'h0));
    vecs.push_back(mk("blez_pos",    1, BLEZ,   5'h00, 16'h0010, 32'h0000_2000, 32'd1,         32'd9, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk("blez_neg",    1, BLEZ,   5'h00, 16'h0010, 32'h0000_2000, 32'h8000_0000, 32'd9, 1, 0, 32'h0000_2044, 32'h0));
    vecs.push_back(mk("bgtz_pos",    1, BGTZ,   5'h00, 16'h0001, 32'h0000_3000, 32'd1,         32'd0, 1, 0, 32'h0000_3008, 32'h0));
    vecs.push_back(mk("bgtz_neg",    1, BGTZ,   5'h00, 16'h0001, 32'h0000_3000, 32'hFFFF_FFFF, 32'd0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk("bgtz_zero",   1, BGTZ,   5'h00, 16'h0001, 32'h0000_3000, 32'd0,         32'd5, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk("bltz_neg",    1, REGIMM, 5'h00, 16'h0002, 32'h0000_4000, 32'h8000_0000, 32'd0, 1, 0, 32'h0000_400C, 32'h0));
    vecs.push_back(mk("bltz_zero",   1, REGIMM, 5'h00, 16'h0002, 32'h0000_4000, 32'd0,         32'd0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk("bgez_pos",    1, REGIMM, 5'h01, 16'h0000, 32'h0000_5000, 32'h7FFF_FFFF, 32'd0, 1, 0, 32'h0000_5004, 32'h0));
    vecs.push_back(mk("bgezal_neg",  1, REGIMM, 5'h11, 16'h0003, 32'h0040_0100, 32'h8000_0000, 32'd0, 0, 1, 32'h0,         32'h0040_0108));
    vecs.push_back(mk("bgezal_zero", 1, REGIMM, 5'h11, 16'h0003, 32'h0040_0100, 32'd0,         32'd0, 1, 1, 32'h0040_0110, 32'h0040_0108));
    vecs.push_back(mk("bltzal_neg",  1, REGIMM, 5'h10, 16'h0000, 32'h0000_6000, 32'hFFFF_FFFF, 32'd0, 1, 1, 32'h0000_6004, 32'h0000_6008));
    vecs.push_back(mk("beq_negimm",  1, BEQ,    5'h00, 16'h8000, 32'h0040_0000, 32'd9,         32'd9, 1, 0, 32'h003E_0004, 32'h0));
    vecs.push_back(mk("beq_wrap",    1, BEQ,    5'h00, 16'h0001, 32'hFFFF_FFF8, 32'd3,         32'd3, 1, 0, 32'h0000_0000, 32'h0));
    vecs.push_back(mk("nop",         0, NOP,    5'h00, 16'h0004, 32'h0000_7000, 32'd0,         32'd0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk("regimm_rt2",  0, REGIMM, 5'h02, 16'h0004, 32'h0000_7000, 32'h8000_0000, 32'd0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk("jump",        0, J,      5'h00, 16'h0004, 32'h0000_7000, 32'd0,         32'd0, 0, 0, 32'h0,         32'h0));

    // ---- Reset state ----
    idle_inputs();
    resetn = 1'b0;
    step(); step();
    @(negedge clk);
    check("rst_stall",     {31'd0, br_stall},    32'd0);
    check("rst_redirect",  {31'd0, br_redirect}, 32'd0);
    check("rst_link",      {31'd0, br_link},     32'd0);
    check("rst_target",    br_target,            32'd0);
    check("rst_link_addr", br_link_addr,         32'd0);
    check("rst_br_cnt",    {16'd0, br_cnt},      32'd0);
    check("rst_taken_cnt", {16'd0, taken_cnt},   32'd0);
    step();
    resetn = 1'b1;
    step();

    // ---- Table ----
    foreach (vecs[i]) apply_vec(vecs[i]);

    // ---- BNE waiting on rt: WAIT x3 then EVAL, not taken ----
    drive_branch(BNE, 5'h00, 16'h0001, 32'h0000_0100, 32'd7, 32'd7, 1'b1, 1'b0);
    stall_cycles = 0;
    redir_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (br_stall)    stall_cycles++;
      if (br_redirect) redir_cycles++;
      step();
      id_op    = NOP;
      rt_ready = (k + 1 == 3);
    end
    bc_exp = bc_exp + 16'd1;
    check("bne_wait_stall_cycles", stall_cycles, 4);
    check("bne_wait_redirects",    redir_cycles, 0);
    check("bne_wait_br_cnt",       {16'd0, br_cnt},    {16'd0, bc_exp});
    check("bne_wait_taken_cnt",    {16'd0, taken_cnt}, {16'd0, tc_exp});
    idle_inputs();
    step();

    // ---- BLTZ taken with pipe_stall held for 2 EVAL cycles ----
    drive_branch(REGIMM, 5'h00, 16'h0004, 32'h0000_7000, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    step();
    id_op = NOP; rs_ready = 1'b0; pipe_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bltz_stalled_redirect", {31'd0, br_redirect}, 32'd0);
      check("bltz_stalled_br_stall", {31'd0, br_stall},    32'd1);
      check("bltz_stalled_br_cnt",   {16'd0, br_cnt},      {16'd0, bc_exp});
      step();
    end
    pipe_stall = 1'b0;
    @(negedge clk);
    check("bltz_release_redirect", {31'd0, br_redirect}, 32'd1);
    check("bltz_release_target",   br_target,            32'h0000_7014);
    bc_exp = bc_exp + 16'd1;
    tc_exp = tc_exp + 16'd1;
    step();
    @(negedge clk);
    check("bltz_dslot_redirect", {31'd0, br_redirect}, 32'd0);
    check("bltz_br_cnt",         {16'd0, br_cnt},      {16'd0, bc_exp});
    check("bltz_taken_cnt",      {16'd0, taken_cnt},   {16'd0, tc_exp});
    step();
    idle_inputs();
    step();

    // ---- Flush in WAIT ----
    drive_branch(BEQ, 5'h00, 16'h0004, 32'h0000_8000, 32'd1, 32'd1, 1'b0, 1'b0);
    step();
    id_op = NOP; flush = 1'b1;
    @(negedge clk);
    check("flush_wait_stall",    {31'd0, br_stall},    32'd1);
    check("flush_wait_redirect", {31'd0, br_redirect}, 32'd0);
    step();
    flush = 1'b0; rs_ready = 1'b1; rt_ready = 1'b1;
    @(negedge clk);
    check("flush_wait_idle", {31'd0, br_stall}, 32'd0);
    step();
    @(negedge clk);
    check("flush_wait_stays_idle", {31'd0, br_stall},    32'd0);
    check("flush_wait_no_redir",   {31'd0, br_redirect}, 32'd0);
    check("flush_wait_br_cnt",     {16'd0, br_cnt},      {16'd0, bc_exp});
    idle_inputs();
    step();

    // ---- Flush in EVAL (taken BGEZAL) ----
    drive_branch(REGIMM, 5'h11, 16'h0004, 32'h0000_9000, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    id_op = NOP; rs_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_eval_redirect", {31'd0, br_redirect}, 32'd0);
    check("flush_eval_link",     {31'd0, br_link},     32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_eval_idle",      {31'd0, br_stall},  32'd0);
    check("flush_eval_br_cnt",    {16'd0, br_cnt},    {16'd0, bc_exp});
    check("flush_eval_taken_cnt", {16'd0, taken_cnt}, {16'd0, tc_exp});
    idle_inputs();
    step();

    // ---- Reset pulse in EVAL ----
    drive_branch(BEQ, 5'h00, 16'h0004, 32'h0000_A000, 32'd2, 32'd2, 1'b1, 1'b1);
    step();
    idle_inputs();
    resetn = 1'b0;
    #1;
    check("rst_eval_stall",     {31'd0, br_stall},    32'd0);
    check("rst_eval_redirect",  {31'd0, br_redirect}, 32'd0);
    check("rst_eval_target",    br_target,            32'd0);
    check("rst_eval_link_addr", br_link_addr,         32'd0);
    check("rst_eval_br_cnt",    {16'd0, br_cnt},      32'd0);
    check("rst_eval_taken_cnt", {16'd0, taken_cnt},   32'd0);
    bc_exp = '0;
    tc_exp = '0;
    step();
    resetn = 1'b1;
    redir_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (br_redirect) redir_cycles++;
      step();
    end
    check("rst_eval_no_redirect_after", redir_cycles, 0);

    // ---- taken_cnt wrap FFFF -> 0000 ----
    force dut.taken_cnt = 16'hFFFF;
    #1;
    release dut.taken_cnt;
    tc_exp = 16'hFFFF;
    apply_vec(mk("wrap_taken", 1, BEQ, 5'h00, 16'h0002, 32'h0000_B000, 32'd4, 32'd4, 1, 0, 32'h0000_B00C, 32'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: id_valid  in  1  instruction present in ID.
REQ-004 SHALL have port: id_op  in  6  opcode field (MIPS encoding: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, REGIMM 000001).
REQ-005 SHALL have port: id_rt  in  5  rt field (REGIMM: BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001).
REQ-006 SHALL have port: id_imm  in  16  branch offset.
REQ-007 SHALL have port: id_pc  in  32  PC of branch.
REQ-008 SHALL have ports: rs_data, rt_data  in  32  forwarded operands; rs_ready, rt_ready  in  1  operand valid this cycle.
REQ-009 SHALL have ports: pipe_stall  in  1  downstream hold; flush  in  1  exception flush.
REQ-010 SHALL have ports: br_stall  out  1  hold IF/ID; br_redirect  out  1  load br_target into PC.
REQ-011 SHALL have ports: br_target  out  32  taken target; br_link  out  1  write r31; br_link_addr  out  32  link value.
REQ-012 SHALL have ports: br_cnt, taken_cnt  out  16  resolved and taken branch counters.

Function
REQ-013 SHALL treat as branch: id_valid with BEQ/BNE/BLEZ/BGTZ, or REGIMM with rt in {BLTZ,BGEZ,BLTZAL,BGEZAL}; everything else is ignored.
REQ-014 SHALL need rs and rt for BEQ/BNE; rs only for all other branches.
REQ-015 SHALL implement states IDLE, WAIT, EVAL, DSLOT.
REQ-016 IDLE: branch with !pipe_stall latches op, rt, pc, imm; needed operands ready -> latch operands, go EVAL; otherwise go WAIT.
REQ-017 WAIT: br_stall=1; each cycle all needed operands ready -> latch them, go EVAL; otherwise stay.
REQ-018 EVAL: br_stall=1; evaluate latched operands: BEQ a==b; BNE a!=b; BGTZ a>0 signed; BLEZ a<=0; BGEZ/BGEZAL a>=0; BLTZ/BLTZAL a<0.
REQ-019 EVAL: br_redirect=taken & !pipe_stall; pipe_stall=1 -> stay in EVAL, outputs held; else go DSLOT.
REQ-020 br_target SHALL be latched pc + 4 + (sign_extend(imm) << 2), 32-bit wrap-around, valid whenever br_redirect=1.
REQ-021 br_link SHALL be 1 in EVAL for BGEZAL/BLTZAL regardless of outcome; br_link_addr = latched pc + 8.
REQ-022 DSLOT: br_stall=0; id_valid & !pipe_stall (delay slot accepted) -> IDLE; branch in delay slot is not sequenced (unsupported).
REQ-023 br_cnt SHALL increment on leaving EVAL; taken_cnt also if taken; both 16-bit, wrap FFFF->0000.
REQ-024 flush SHALL force IDLE next edge from any state, suppress br_redirect and br_link that cycle, and not increment counters.
REQ-025 Outputs SHALL be driven only by state and latched data, except rs/rt readiness sampling; br_redirect is exactly one cycle per taken branch.

Reset
REQ-026 resetn=0 SHALL immediately set state IDLE; br_stall, br_redirect, br_link=0; br_target, br_link_addr, br_cnt, taken_cnt=0; latched fields=0.
REQ-027 Reset mid-operation SHALL abandon the branch with no redirect after release.

Verification
REQ-028 BEQ pc=0x00400000, imm=0x0004, rs=rt=5, ready -> EVAL next cycle, br_redirect=1 one cycle, br_target=0x00400014, br_cnt=1, taken_cnt=1.
REQ-029 BNE rs=rt=7, rt_ready low 3 cycles -> br_stall=1 for 4 cycles (WAIT x3 + EVAL), no redirect, br_cnt+1, taken_cnt unchanged.
REQ-030 BGEZAL rs=0x80000000, pc=0x00400100 -> br_link=1, br_link_addr=0x00400108, br_redirect=0; BGEZAL rs=0 -> br_redirect=1.
REQ-031 BLTZ taken, pipe_stall=1 during EVAL 2 cycles -> br_redirect=0 while stalled, then single pulse; counter increments once.
REQ-032 flush asserted in WAIT and in EVAL -> IDLE next cycle, no redirect, counters unchanged; resetn pulse in EVAL -> all outputs 0.
REQ-033 taken_cnt=0xFFFF plus taken branch -> taken_cnt=0x0000; imm=0x8000 -> br_target=pc+4-0x20000.
